// File: rtl/dii_package.sv
// Shared DI flit type and event FLAGS constants used by the NA bridge blocks.
package dii_package;

  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic        last;
  } dii_flit;

  localparam logic [1:0] TYPE_EVENT        = 2'b10;
  localparam logic [3:0] TYPE_SUB_LAST     = 4'h0;
  localparam logic [3:0] TYPE_SUB_CONTINUE = 4'h1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/di_na_bridge_depacketizer.sv
// Strips DEST/SRC/FLAGS from DI packets and reassembles multi-segment event
// payloads into one word stream whose final word carries in_flit_last.
module di_na_bridge_depacketizer
  import dii_package::*;
#(
  parameter int MAX_DATA_NUM_WORDS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  dii_flit     debug_in,
  output logic        debug_in_ready,
  input  logic [15:0] id,
  output logic [15:0] in_flit_data,
  output logic        in_flit_valid,
  output logic        in_flit_last,
  input  logic        in_flit_ready,
  output logic [7:0]  drop_cnt,
  output logic        err_oversize
);

  localparam int CW = $clog2(MAX_DATA_NUM_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA_NUM_WORDS);

  localparam logic [2:0] ST_DEST    = 3'd0;
  localparam logic [2:0] ST_SRC     = 3'd1;
  localparam logic [2:0] ST_FLAGS   = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;

  logic [2:0]    state;
  logic          stage_valid;
  logic          stage_last;
  logic [15:0]   stage_data;
  logic          final_seg;
  logic          oversized;
  logic [CW-1:0] word_cnt;

  logic       accept;
  logic       emit;
  logic       at_limit;
  logic       stage_hold;
  logic [1:0] flag_type;
  logic [3:0] flag_sub;
  logic       flags_ok;
  logic       flags_final;

  assign at_limit    = (word_cnt == CNT_MAX);
  assign stage_hold  = stage_valid & stage_last;
  assign flag_type   = debug_in.data[15:14];
  assign flag_sub    = debug_in.data[13:10];
  assign flags_ok    = (flag_type == TYPE_EVENT) &&
                       ((flag_sub == TYPE_SUB_LAST) || (flag_sub == TYPE_SUB_CONTINUE));
  assign flags_final = (flag_sub == TYPE_SUB_LAST);

  // Once the event limit is hit, surplus words are swallowed without touching the stage
  always_comb begin
    if (stage_hold) begin
      debug_in_ready = 1'b0;
    end else if ((state == ST_PAYLOAD) && !at_limit) begin
      debug_in_ready = !stage_valid | in_flit_ready;
    end else begin
      debug_in_ready = 1'b1;
    end
  end

  // A staged word may leave only when its successor is on the input, or it is the event end
  assign in_flit_valid = stage_valid &
                         (stage_last | ((state == ST_PAYLOAD) & !at_limit & debug_in.valid));
  assign in_flit_data  = stage_data;
  assign in_flit_last  = stage_last;

  assign accept = debug_in.valid & debug_in_ready;
  assign emit   = in_flit_valid & in_flit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_DEST;
      stage_valid  <= 1'b0;
      stage_last   <= 1'b0;
      stage_data   <= 16'h0000;
      final_seg    <= 1'b0;
      oversized    <= 1'b0;
      word_cnt     <= '0;
      drop_cnt     <= 8'h00;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= 1'b0;
      if (emit) begin
        stage_valid <= 1'b0;
        stage_last  <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_DEST: begin
            if (debug_in.last) begin
              drop_cnt <= sat_inc8(drop_cnt);
            end else if (debug_in.data == id) begin
              state <= ST_SRC;
            end else begin
              state <= ST_DROP;
            end
          end
          ST_SRC: begin
            if (debug_in.last) begin
              drop_cnt <= sat_inc8(drop_cnt);
              state    <= ST_DEST;
            end else begin
              state <= ST_FLAGS;
            end
          end
          ST_FLAGS: begin
            if (!flags_ok) begin
              if (debug_in.last) begin
                drop_cnt <= sat_inc8(drop_cnt);
                state    <= ST_DEST;
              end else begin
                state <= ST_DROP;
              end
            end else begin
              final_seg <= flags_final;
              if (!debug_in.last) begin
                state <= ST_PAYLOAD;
              end else begin
                state <= ST_DEST;
                // Empty final segment closes whatever the stage already holds
                if (flags_final) begin
                  word_cnt  <= '0;
                  oversized <= 1'b0;
                  if (stage_valid) begin
                    stage_last <= 1'b1;
                  end else begin
                    drop_cnt <= sat_inc8(drop_cnt);
                  end
                end
              end
            end
          end
          ST_PAYLOAD: begin
            if (debug_in.last) begin
              state <= ST_DEST;
            end
            if (at_limit) begin
              oversized    <= 1'b1;
              err_oversize <= !oversized;
              if (debug_in.last && final_seg) begin
                word_cnt  <= '0;
                oversized <= 1'b0;
                if (stage_valid) begin
                  stage_last <= 1'b1;
                end
              end
            end else begin
              stage_valid <= 1'b1;
              stage_data  <= debug_in.data;
              stage_last  <= debug_in.last & final_seg;
              word_cnt    <= (debug_in.last && final_seg) ? '0 : word_cnt + CW'(1);
            end
          end
          ST_DROP: begin
            if (debug_in.last) begin
              drop_cnt <= sat_inc8(drop_cnt);
              state    <= ST_DEST;
            end
          end
          default: begin
            state <= ST_DEST;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_di_na_bridge_depacketizer.sv
// Randomized bench for di_na_bridge_depacketizer with a packet-level event model.
module tb_di_na_bridge_depacketizer;
  import dii_package::*;

  localparam int MAXW = 12;

  logic        clk = 1'b0;
  logic        rst;
  dii_flit     din;
  logic        din_ready;
  logic [15:0] id;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic        err_oversize;

  int errors = 0;
  int checks = 0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  logic [15:0] pkt[$];
  logic [15:0] m_ev[$];
  int m_drop, m_err, m_cnt;
  bit m_ovf;
  int err_seen = 0;
  int acc_cnt = 0;
  int rdy_mode = 2;

  always #5 clk = ~clk;

  di_na_bridge_depacketizer #(.MAX_DATA_NUM_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .debug_in(din), .debug_in_ready(din_ready), .id(id),
    .in_flit_data(out_data), .in_flit_valid(out_valid), .in_flit_last(out_last),
    .in_flit_ready(out_ready), .drop_cnt(drop_cnt), .err_oversize(err_oversize)
  );

  // Observe handshakes mid-cycle, when all inputs for the cycle are settled
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
      if (err_oversize) err_seen <= err_seen + 1;
      if (din.valid && din_ready) acc_cnt <= acc_cnt + 1;
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic model_reset();
    m_drop = 0; m_err = 0; m_cnt = 0; m_ovf = 0;
    m_ev.delete(); exp_q.delete(); obs_q.delete();
  endtask

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
  endtask

  // Event-level reference: collect payload per event, publish it when a final segment closes it
  task automatic model_pkt();
    logic [15:0] fl;
    logic [15:0] w;
    if (pkt.size() < 3 || pkt[0] !== id) begin
      model_drop();
      return;
    end
    fl = pkt[2];
    if (fl[15:14] != 2'b10 || fl[13:10] > 4'd1) begin
      model_drop();
      return;
    end
    for (int i = 3; i < pkt.size(); i++) begin
      if (m_cnt < MAXW) begin
        m_ev.push_back(pkt[i]);
        m_cnt++;
      end else if (!m_ovf) begin
        m_ovf = 1;
        m_err++;
      end
    end
    if (fl[13:10] == 4'd0) begin
      if (m_ev.size() == 0) model_drop();
      while (m_ev.size() > 0) begin
        w = m_ev.pop_front();
        exp_q.push_back({(m_ev.size() == 0), w});
      end
      m_cnt = 0;
      m_ovf = 0;
    end
  endtask

  task automatic send(input bit no_last);
    int t;
    for (int i = 0; i < pkt.size(); i++) begin
      din.valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      din.data  = pkt[i];
      din.valid = 1'b1;
      din.last  = !no_last && (i == pkt.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (din_ready) begin @(posedge clk); #1; break; end
        @(posedge clk); #1;
        t++;
        if (t > 300) begin
          checks++; errors++;
          $display("FAIL send_timeout: flit %0d not accepted within %0d cycles", i, t);
          break;
        end
      end
    end
    din.valid = 1'b0;
    din.last  = 1'b0;
  endtask

  task automatic wait_outputs(output bit timed_out);
    int t = 0;
    timed_out = 0;
    while (obs_q.size() < exp_q.size()) begin
      @(posedge clk); #1;
      t++;
      if (t > 2000) begin timed_out = 1; break; end
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    din = '0; id = 16'h0005; rdy_mode = 2; rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", din_ready); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %0h want 0", drop_cnt); end
    checks++; if (err_oversize !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_oversize); end
  endtask

  task automatic test_basic();
    bit to;
    obs_q.delete(); exp_q.delete();
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'hAAAA, 16'hBBBB};
    send(0); model_pkt();
    wait_outputs(to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    checks++; if (exp_q.size() != 2 || exp_q[1] !== 17'h1BBBB) begin errors++; $display("FAIL basic_model: model produced %0d words", exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_segments();
    bit to;
    obs_q.delete(); exp_q.delete();
    pkt = '{16'h0005, 16'h0001, 16'h8400, 16'h0001, 16'h0002};
    send(0); model_pkt();
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0003};
    send(0); model_pkt();
    wait_outputs(to);
    checks++; if (to) begin errors++; $display("FAIL seg_timeout: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL seg_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL seg_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_drop_dest();
    int acc0;
    obs_q.delete(); exp_q.delete();
    acc0 = acc_cnt;
    pkt = '{16'h0007, 16'h0001, 16'h8000, 16'h1111, 16'h2222};
    send(0); model_pkt();
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL drop_output: got %0d words want 0", obs_q.size()); end
    checks++; if (drop_cnt !== 8'(m_drop) || m_drop != 1) begin errors++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, m_drop); end
    checks++; if (acc_cnt - acc0 != 5) begin errors++; $display("FAIL drop_accepted: got %0d want 5", acc_cnt - acc0); end
  endtask

  task automatic test_empty_final();
    bit to;
    obs_q.delete(); exp_q.delete();
    pkt = '{16'h0005, 16'h0001, 16'h8400, 16'h0001};
    send(0); model_pkt();
    pkt = '{16'h0005, 16'h0001, 16'h8000};
    send(0); model_pkt();
    wait_outputs(to);
    checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL empty_final_count: got %0d want 1", obs_q.size()); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 17'h10001) begin errors++; $display("FAIL empty_final_word: got %h want 10001", obs_q[0]); end
    checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL empty_final_drop: got %0d want %0d", drop_cnt, m_drop); end
  endtask

  task automatic test_oversize();
    bit to;
    int e0;
    obs_q.delete(); exp_q.delete();
    e0 = err_seen;
    pkt = '{16'h0005, 16'h0001, 16'h8000};
    for (int i = 1; i <= 14; i++) pkt.push_back(16'h0100 + 16'(i));
    send(0); model_pkt();
    wait_outputs(to);
    checks++; if (to || obs_q.size() != 12) begin errors++; $display("FAIL oversize_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL oversize_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL oversize_pulse: got %0d pulses want 1", err_seen - e0); end
  endtask

  task automatic test_random();
    bit to;
    int r, n, e0, merr0;
    obs_q.delete(); exp_q.delete();
    e0 = err_seen; merr0 = m_err;
    rdy_mode = 0;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      pkt.delete();
      case (r)
        0: begin
          pkt.push_back(16'h0005);
          if ($urandom_range(0, 1) == 1) pkt.push_back(16'($urandom));
        end
        1: begin
          pkt.push_back(16'h0006 + 16'($urandom_range(0, 100)));
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
        end
        2: begin
          pkt.push_back(16'h0005); pkt.push_back(16'($urandom));
          pkt.push_back({2'b01, 4'($urandom_range(0, 15)), 10'($urandom)});
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
        end
        default: begin
          pkt.push_back(16'h0005); pkt.push_back(16'($urandom));
          pkt.push_back({2'b10, ($urandom_range(0, 1) == 1) ? 4'h1 : 4'h0, 10'($urandom)});
          n = (r == 9) ? $urandom_range(10, 16) : $urandom_range(0, 5);
          for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
        end
      endcase
      send(0); model_pkt();
    end
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'hCAFE};
    send(0); model_pkt();
    wait_outputs(to);
    checks++; if (to || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rand_drop: got %0d want %0d", drop_cnt, m_drop); end
    checks++; if (err_seen - e0 != m_err - merr0) begin errors++; $display("FAIL rand_err: got %0d want %0d", err_seen - e0, m_err - merr0); end
    rdy_mode = 2;
  endtask

  task automatic test_reset_mid();
    bit to;
    rdy_mode = 1;
    repeat (3) begin @(posedge clk); #1; end
    obs_q.delete(); exp_q.delete();
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0011};
    send(1);
    din.data = 16'h0022; din.valid = 1'b1; din.last = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++; if (din_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall: got ready=%b valid=%b want 0/1", din_ready, out_valid); end
    end
    @(posedge clk); #1;
    rst = 1'b1; din.valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; rdy_mode = 2;
    model_reset();
    repeat (20) begin @(posedge clk); #1; end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_output: got %0d words want 0", obs_q.size()); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", din_ready); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_mid_drop: got %0d want 0", drop_cnt); end
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'hAAAA, 16'hBBBB};
    send(0); model_pkt();
    wait_outputs(to);
    checks++; if (to || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_after_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_after_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_segments();
    test_drop_dest();
    test_empty_final();
    test_oversize();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/di_na_bridge_depacketizer.md
DI_NA_BRIDGE_DEPACKETIZER -- requirements
Module: di_na_bridge_depacketizer

Interface
REQ-001: Parameter MAX_DATA_NUM_WORDS, default 12; maximum number of payload words in one reassembled event.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: rst  input  1  reset; synchronous, active-high.
REQ-004: debug_in  input  dii_flit  incoming DI flit (data[15:0], valid, last).
REQ-005: debug_in_ready  output  1  DI flit accepted when debug_in.valid & debug_in_ready.
REQ-006: id  input  16  DI address of this module; expected DEST.
REQ-007: in_flit_data  output  16  reassembled payload word.
REQ-008: in_flit_valid  output  1  in_flit_data is valid.
REQ-009: in_flit_last  output  1  word is the final word of an event.
REQ-010: in_flit_ready  input  1  consumer accepts the word when in_flit_valid & in_flit_ready.
REQ-011: drop_cnt  output  8  saturating count of discarded DI packets.
REQ-012: err_oversize  output  1  one-cycle pulse when an event exceeds MAX_DATA_NUM_WORDS.

Function
REQ-013: DI packet layout: flit0 DEST, flit1 SRC, flit2 FLAGS, flit3..n payload; debug_in.last marks the final flit of the DI packet.
REQ-014: FLAGS[15:14] = TYPE_EVENT (2'b10) required; FLAGS[13:10] type_sub: 4'h0 = final segment of event, 4'h1 = continuation segment.
REQ-015: States: DEST, SRC, FLAGS, PAYLOAD, DROP; reset state DEST.
REQ-016: DEST: on accept, go to SRC if data == id, else DROP; a DEST flit with last=1 counts as a drop and stays in DEST.
REQ-017: SRC: on accept, go to FLAGS; SRC value is ignored; SRC with last=1 counts as a drop and returns to DEST.
REQ-018: FLAGS: on accept, register final = (type_sub == 4'h0); go to PAYLOAD; if type != TYPE_EVENT or type_sub not in {0,1}, go to DROP instead; FLAGS with last=1 goes to DEST.
REQ-019: DROP: accept every flit (debug_in_ready=1); on last go to DEST; drop_cnt increments once per discarded DI packet, saturating at 8'hFF.
REQ-020: In DEST, SRC, FLAGS, DROP states debug_in_ready = 1.
REQ-021: A one-word stage register (stage_valid, stage_data, stage_last) holds the most recent payload word until its last-ness is known.
REQ-022: in_flit_valid = stage_valid & (stage_last | (state==PAYLOAD & debug_in.valid)); in_flit_data = stage_data; in_flit_last = stage_last.
REQ-023: PAYLOAD with stage empty or stage_last=0: debug_in_ready = !stage_valid | in_flit_ready; the accepted word loads the stage and the previous stage word is emitted in the same cycle.
REQ-024: Accepted payload word with last=1 and final=1 loads stage_last=1; state goes to DEST.
REQ-025: Accepted payload word with last=1 and final=0 leaves stage_last=0; state goes to DEST; the stage is held across segments.
REQ-026: FLAGS flit with last=1 and final=1 (empty final segment): set stage_last=1 if stage_valid; if stage empty, count as drop.
REQ-027: While stage_last=1, debug_in_ready=0 in every state until the stage drains (in_flit_valid & in_flit_ready clears stage_valid).
REQ-028: Per-event word counter (width $clog2(MAX_DATA_NUM_WORDS+1)) increments on each payload accept and clears after a final word; words beyond MAX_DATA_NUM_WORDS are discarded without loading the stage; err_oversize pulses on the first discarded word.
REQ-029: Latency: first payload word appears on in_flit_* no earlier than the cycle the next payload word (or event end) is observed; zero added latency beyond that.

Reset
REQ-030: On rst: state=DEST, stage_valid=0, stage_last=0, final=0, word counter=0, drop_cnt=0, err_oversize=0; in_flit_valid=0 and debug_in_ready=1 in the first cycle after reset.
REQ-031: rst asserted mid-event discards any partially reassembled event; no word of it is emitted after reset.

Structure
REQ-032: TYPE_EVENT, TYPE_SUB_LAST (4'h0), TYPE_SUB_CONTINUE (4'h1) constants live in dii_package next to dii_flit; no local redefinition.
REQ-033: Single module, no sub-module; a noc_buffer for full-packet buffering, if needed, is instantiated by the parent, not here.

Verification
REQ-034: id=16'h0005; DI packet 0005,0001,8000(final),AAAA,BBBB(last) -> out AAAA(last=0), BBBB(last=1).
REQ-035: Segment 0005,0001,8400,0001,0002(last) then 0005,0001,8000,0003(last) -> out 0001,0002,0003, last only on 0003.
REQ-036: Packet with DEST=0007 and 5 flits -> no output, drop_cnt 0->1, all 5 flits accepted.
REQ-037: Continuation segment with 0001(last) followed by empty final 0005,0001,8000(last) -> out 0001 with last=1.
REQ-038: 14 payload words in one final segment, MAX_DATA_NUM_WORDS=12 -> 12 words out, last on word 12, err_oversize one pulse.
REQ-039: in_flit_ready held 0 for 10 cycles mid-event, then rst asserted -> no output afterwards, state DEST, drop_cnt=0.
